// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_buf
// Purpose  : Generic two-entry (main + skid) inter-stage pipeline register
//            with valid/ready handshake on both sides, back-pressure and a
//            synchronous flush that inserts a bubble. Control and data are
//            held separately so that a bubble always presents zero control.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous, active-high
//            in_valid   - upstream entry valid
//            in_ready   - buffer can accept this cycle (state-decoded only)
//            in_ctrl    - upstream control bundle  [CTRL_W]
//            in_data    - upstream data bundle     [DATA_W]
//            flush      - synchronous kill of all held entries
//            out_valid  - main entry valid
//            out_ready  - downstream consumes the main entry this cycle
//            out_ctrl   - main control, forced to zero when out_valid=0
//            out_data   - main data
//            occupancy  - number of held entries (0..2)
//            flush_cnt  - saturating count of valid entries killed by flush
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_buf #(
  parameter int CTRL_W     = 10,
  parameter int DATA_W     = 143,
  parameter int CLEAR_DATA = 0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  flush_cnt
);

  // State encoding equals the number of held entries.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                w_accept;
  logic                w_drain;
  logic [1:0]          w_discard;
  logic [CNT_W:0]      w_cnt_sum;

  // in_ready depends on state only, never on out_ready.
  assign in_ready  = (state_q != S_FULL);
  assign out_valid = (state_q != S_EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_drain   = out_valid & out_ready;

  // Entries killed by a flush: everything held minus one that drains in the
  // same cycle (a drain implies at least one entry, so no underflow).
  assign w_discard = 2'(state_q) - {1'b0, w_drain};
  assign w_cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(w_discard);

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    cnt_d       = cnt_q;

    if (flush) begin
      // Flush wins over accept and drain; the incoming entry is dropped.
      state_d     = S_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLEAR_DATA != 0) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
      cnt_d = w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (w_accept) begin
            state_d     = S_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        S_ONE: begin
          if (w_accept && w_drain) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (w_accept) begin
            state_d     = S_FULL;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (w_drain) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          // No accept possible here; a drain promotes the skid entry.
          if (w_drain) begin
            state_d     = S_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      cnt_q       <= cnt_d;
    end
  end

  // Gate control so an empty buffer always presents a bubble downstream.
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign out_data  = main_data_q;
  assign occupancy = 2'(state_q);
  assign flush_cnt = cnt_q;

endmodule
`default_nettype wire
